// File: rtl/cv32e40p_obi_fetch_arbiter.sv
// Shares one OBI memory port between the instruction fetch port and the LSU data port.
// Address phases are arbitrated with fixed data priority or round-robin, and the choice
// is held while a request waits for grant. An owner FIFO routes the in-order responses.
// Ports: clk, rst_n; instr_* and data_* OBI slave ports toward the core;
//        mem_* OBI master port toward the memory; busy_o, proto_err_o status.
module cv32e40p_obi_fetch_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          DATA_PRIO       = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        busy_o,
   output logic        proto_err_o
);

   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ?
                                $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

   // owner encoding: 0 = fetch, 1 = LSU
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   typedef enum logic {
      ST_UNLOCKED,
      ST_LOCKED
   } lock_e;

   lock_e                r_state;
   lock_e                w_state_nxt;
   logic                 r_lock_own;
   logic                 w_lock_own_nxt;
   logic                 r_rr_last;
   logic [MAX_OUTSTANDING-1:0] r_fifo;
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_proto_err;

   logic                 w_sel;
   logic                 w_sel_req;
   logic                 w_room;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_empty;
   logic                 w_head;

   // Port selection; a locked request keeps its owner until granted or retracted
   always_comb begin
      w_sel = OWN_I;
      if (r_state == ST_LOCKED) begin
         w_sel = r_lock_own;
      end else if (data_req_i && !instr_req_i) begin
         w_sel = OWN_D;
      end else if (data_req_i && instr_req_i) begin
         w_sel = DATA_PRIO ? OWN_D : ~r_rr_last;
      end
   end

   assign w_sel_req = w_sel ? data_req_i : instr_req_i;
   // No bypass: a full FIFO blocks issue even if a response pops this cycle
   assign w_room    = (r_count < MAXC);
   assign mem_req_o = w_sel_req & w_room;
   assign w_push    = mem_req_o & mem_gnt_i;

   assign mem_addr_o  = w_sel ? data_addr_i  : instr_addr_i;
   assign mem_we_o    = w_sel ? data_we_i    : 1'b0;
   assign mem_be_o    = w_sel ? data_be_i    : 4'hF;
   assign mem_wdata_o = w_sel ? data_wdata_i : 32'h0;

   assign instr_gnt_o = w_push & (w_sel == OWN_I);
   assign data_gnt_o  = w_push & (w_sel == OWN_D);

   always_comb begin
      w_state_nxt    = r_state;
      w_lock_own_nxt = r_lock_own;
      case (r_state)
         ST_UNLOCKED: begin
            if (mem_req_o && !mem_gnt_i) begin
               w_state_nxt    = ST_LOCKED;
               w_lock_own_nxt = w_sel;
            end
         end
         ST_LOCKED: begin
            if (mem_gnt_i || !w_sel_req) begin
               w_state_nxt = ST_UNLOCKED;
            end
         end
         default: w_state_nxt = ST_UNLOCKED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_UNLOCKED;
         r_lock_own <= OWN_I;
         r_rr_last  <= OWN_I;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_own <= w_lock_own_nxt;
         if (w_push) begin
            r_rr_last <= w_sel;
         end
      end
   end

   assign w_empty = (r_count == '0);
   // A response with nothing outstanding is not routed and leaves the FIFO alone
   assign w_pop   = mem_rvalid_i & ~w_empty;
   assign w_head  = r_fifo[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo      <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_sel;
            r_wptr         <= (r_wptr == LASTP) ? '0 : r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LASTP) ? '0 : r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (mem_rvalid_i && w_empty) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign instr_rvalid_o = w_pop & (w_head == OWN_I);
   assign data_rvalid_o  = w_pop & (w_head == OWN_D);
   assign instr_err_o    = instr_rvalid_o & mem_err_i;
   assign data_err_o     = data_rvalid_o & mem_err_i;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

   assign busy_o      = ~w_empty;
   assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_cv32e40p_obi_fetch_arbiter.sv
// Directed bench for cv32e40p_obi_fetch_arbiter: data-priority and round-robin
// instances share stimulus; expected values are hand-computed per step.
module tb_cv32e40p_obi_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_err;

   logic        instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_rdata;
   logic        data_gnt, data_rvalid, data_err;
   logic [31:0] data_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        busy, proto_err;

   logic        rr_instr_gnt, rr_instr_rvalid, rr_instr_err;
   logic [31:0] rr_instr_rdata;
   logic        rr_data_gnt, rr_data_rvalid, rr_data_err;
   logic [31:0] rr_data_rdata;
   logic        rr_mem_req, rr_mem_we;
   logic [3:0]  rr_mem_be;
   logic [31:0] rr_mem_addr, rr_mem_wdata;
   logic        rr_busy, rr_proto_err;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cv32e40p_obi_fetch_arbiter #(
      .MAX_OUTSTANDING(2),
      .DATA_PRIO      (1'b1)
   ) u_dp (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_req_i   (instr_req),
      .instr_addr_i  (instr_addr),
      .instr_gnt_o   (instr_gnt),
      .instr_rvalid_o(instr_rvalid),
      .instr_rdata_o (instr_rdata),
      .instr_err_o   (instr_err),
      .data_req_i    (data_req),
      .data_we_i     (data_we),
      .data_be_i     (data_be),
      .data_addr_i   (data_addr),
      .data_wdata_i  (data_wdata),
      .data_gnt_o    (data_gnt),
      .data_rvalid_o (data_rvalid),
      .data_rdata_o  (data_rdata),
      .data_err_o    (data_err),
      .mem_req_o     (mem_req),
      .mem_we_o      (mem_we),
      .mem_be_o      (mem_be),
      .mem_addr_o    (mem_addr),
      .mem_wdata_o   (mem_wdata),
      .mem_gnt_i     (mem_gnt),
      .mem_rvalid_i  (mem_rvalid),
      .mem_rdata_i   (mem_rdata),
      .mem_err_i     (mem_err),
      .busy_o        (busy),
      .proto_err_o   (proto_err)
   );

   cv32e40p_obi_fetch_arbiter #(
      .MAX_OUTSTANDING(2),
      .DATA_PRIO      (1'b0)
   ) u_rr (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_req_i   (instr_req),
      .instr_addr_i  (instr_addr),
      .instr_gnt_o   (rr_instr_gnt),
      .instr_rvalid_o(rr_instr_rvalid),
      .instr_rdata_o (rr_instr_rdata),
      .instr_err_o   (rr_instr_err),
      .data_req_i    (data_req),
      .data_we_i     (data_we),
      .data_be_i     (data_be),
      .data_addr_i   (data_addr),
      .data_wdata_i  (data_wdata),
      .data_gnt_o    (rr_data_gnt),
      .data_rvalid_o (rr_data_rvalid),
      .data_rdata_o  (rr_data_rdata),
      .data_err_o    (rr_data_err),
      .mem_req_o     (rr_mem_req),
      .mem_we_o      (rr_mem_we),
      .mem_be_o      (rr_mem_be),
      .mem_addr_o    (rr_mem_addr),
      .mem_wdata_o   (rr_mem_wdata),
      .mem_gnt_i     (mem_gnt),
      .mem_rvalid_i  (mem_rvalid),
      .mem_rdata_i   (mem_rdata),
      .mem_err_i     (mem_err),
      .busy_o        (rr_busy),
      .proto_err_o   (rr_proto_err)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // move 1ns past the next rising edge; inputs change here
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      instr_req  = 1'b0;
      instr_addr = 32'h0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_be    = 4'h0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      mem_err    = 1'b0;
      #2;
      chk("rst_igrant", {31'd0, instr_gnt}, 32'd0);
      chk("rst_dgrant", {31'd0, data_gnt}, 32'd0);
      chk("rst_memreq", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_perr", {31'd0, proto_err}, 32'd0);
      chk("rst_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
      step();
      step();
      rst_n = 1'b1;

      // single fetch, response next cycle
      step();
      instr_req  = 1'b1;
      instr_addr = 32'h100;
      mem_gnt    = 1'b1;
      #1;
      chk("f_gnt", {31'd0, instr_gnt}, 32'd1);
      chk("f_addr", mem_addr, 32'h100);
      chk("f_be", {28'd0, mem_be}, 32'hF);
      step();
      instr_req  = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h13;
      #1;
      chk("f_rvalid", {31'd0, instr_rvalid}, 32'd1);
      chk("f_rdata", instr_rdata, 32'h13);
      chk("f_drvalid", {31'd0, data_rvalid}, 32'd0);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("f_idle", {31'd0, busy}, 32'd0);

      // data priority under contention
      instr_req  = 1'b1;
      data_req   = 1'b1;
      data_we    = 1'b1;
      data_be    = 4'h3;
      data_addr  = 32'h200;
      data_wdata = 32'hDEAD;
      mem_gnt    = 1'b1;
      #1;
      chk("p1_dgnt", {30'd0, instr_gnt, data_gnt}, 32'd1);
      chk("p1_addr", mem_addr, 32'h200);
      chk("p1_we_be", {27'd0, mem_we, mem_be}, 32'h13);
      chk("p1_wdata", mem_wdata, 32'hDEAD);
      for (int i = 0; i < 2; i++) begin
         step();
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hD0 + i;
         #1;
         chk("p2_dgnt", {30'd0, instr_gnt, data_gnt}, 32'd1);
         chk("p2_drv", {30'd0, instr_rvalid, data_rvalid}, 32'd1);
      end
      step();
      data_req = 1'b0;
      #1;
      chk("p4_igrant", {30'd0, instr_gnt, data_gnt}, 32'd2);
      chk("p4_addr", mem_addr, 32'h100);
      chk("p4_drv", {30'd0, instr_rvalid, data_rvalid}, 32'd1);
      step();
      instr_req = 1'b0;
      mem_gnt   = 1'b0;
      mem_err   = 1'b1;
      #1;
      chk("p5_irv", {30'd0, instr_rvalid, data_rvalid}, 32'd2);
      chk("p5_ierr", {30'd0, instr_err, data_err}, 32'd2);
      step();
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      #1;
      chk("p5_idle", {31'd0, busy}, 32'd0);

      // locked fetch waits while LSU raises req
      instr_req  = 1'b1;
      instr_addr = 32'h140;
      #1;
      chk("l1_addr", mem_addr, 32'h140);
      chk("l1_gnt", {30'd0, instr_gnt, data_gnt}, 32'd0);
      step();
      data_req  = 1'b1;
      data_addr = 32'h240;
      #1;
      chk("l2_addr", mem_addr, 32'h140);
      chk("l2_gnt", {30'd0, instr_gnt, data_gnt}, 32'd0);
      step();
      mem_gnt = 1'b1;
      #1;
      chk("l3_igrant", {30'd0, instr_gnt, data_gnt}, 32'd2);
      chk("l3_addr", mem_addr, 32'h140);
      chk("l3_fetch", {27'd0, mem_we, mem_be}, 32'h0F);
      chk("l3_wdata", mem_wdata, 32'h0);
      step();
      instr_req = 1'b0;
      #1;
      chk("l4_dgrant", {30'd0, instr_gnt, data_gnt}, 32'd1);
      chk("l4_addr", mem_addr, 32'h240);

      // FIFO full: issue blocked until a response pops
      step();
      #1;
      chk("o1_memreq", {31'd0, mem_req}, 32'd0);
      chk("o1_gnt", {30'd0, instr_gnt, data_gnt}, 32'd0);
      chk("o1_busy", {31'd0, busy}, 32'd1);
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hAAAA;
      #1;
      chk("o2_irv", {30'd0, instr_rvalid, data_rvalid}, 32'd2);
      chk("o2_nobypass", {31'd0, mem_req}, 32'd0);
      step();
      mem_rdata = 32'hBBBB;
      #1;
      chk("o3_drv", {30'd0, instr_rvalid, data_rvalid}, 32'd1);
      chk("o3_rdata", data_rdata, 32'hBBBB);
      chk("o3_dgnt", {30'd0, instr_gnt, data_gnt}, 32'd1);
      step();
      data_req = 1'b0;
      mem_gnt  = 1'b0;
      #1;
      chk("o4_drv", {30'd0, instr_rvalid, data_rvalid}, 32'd1);
      step();
      #1;
      chk("o4_idle", {31'd0, busy}, 32'd0);
      chk("o4_perr", {31'd0, proto_err}, 32'd0);

      // stray response while empty
      #1;
      chk("e_rv", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("e_perr", {31'd0, proto_err}, 32'd1);
      step();
      step();
      chk("e_sticky", {31'd0, proto_err}, 32'd1);

      // fill two fetches, then reset mid-flight
      instr_req  = 1'b1;
      instr_addr = 32'h300;
      mem_gnt    = 1'b1;
      step();
      step();
      instr_req = 1'b0;
      mem_gnt   = 1'b0;
      #1;
      chk("r_busy2", {31'd0, busy}, 32'd1);
      rst_n      = 1'b0;
      mem_rvalid = 1'b1;
      #1;
      chk("r_busy0", {31'd0, busy}, 32'd0);
      chk("r_perr0", {31'd0, proto_err}, 32'd0);
      chk("r_rv0", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
      chk("r_gnt0", {30'd0, instr_gnt, data_gnt}, 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("r_rvlate", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("r_perrlate", {31'd0, proto_err}, 32'd1);

      // round-robin instance, clean start
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      instr_req  = 1'b1;
      instr_addr = 32'h400;
      data_req   = 1'b1;
      data_addr  = 32'h500;
      mem_gnt    = 1'b1;
      #1;
      chk("rr1_dgnt", {30'd0, rr_instr_gnt, rr_data_gnt}, 32'd1);
      chk("rr1_addr", rr_mem_addr, 32'h500);
      step();
      mem_rvalid = 1'b1;
      #1;
      chk("rr2_igrant", {30'd0, rr_instr_gnt, rr_data_gnt}, 32'd2);
      chk("rr2_addr", rr_mem_addr, 32'h400);
      chk("rr2_drv", {30'd0, rr_instr_rvalid, rr_data_rvalid}, 32'd1);
      step();
      #1;
      chk("rr3_dgnt", {30'd0, rr_instr_gnt, rr_data_gnt}, 32'd1);
      chk("rr3_irv", {30'd0, rr_instr_rvalid, rr_data_rvalid}, 32'd2);
      step();
      #1;
      chk("rr4_igrant", {30'd0, rr_instr_gnt, rr_data_gnt}, 32'd2);
      step();
      instr_req  = 1'b0;
      data_req   = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
